// File: rtl/sha2_round_core_if.sv
// sha2_round_core_if: block request / round-feed / result bus of the SHA-2 round core
interface sha2_round_core_if #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
);
  localparam int IDX_W = $clog2(ROUNDS);
  logic start;
  logic [8*WORD_W-1:0] prev_hash;
  logic [WORD_W-1:0] w_in;
  logic [WORD_W-1:0] k_in;
  logic [IDX_W-1:0] round_idx;
  logic ready;
  logic busy;
  logic done;
  logic [8*WORD_W-1:0] digest;
  modport master(output start, prev_hash, w_in, k_in, input round_idx, ready, busy, done, digest);
  modport slave(input start, prev_hash, w_in, k_in, output round_idx, ready, busy, done, digest);
endinterface

// File: rtl/sha2_round_core.sv
// sha2_round_core: iterative SHA-256/SHA-512 compression, one round per clock; SHA2_ROUND_CORE_ABORT_EN adds an abort input
module sha2_round_core #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input logic clock,
  input logic reset,
`ifdef SHA2_ROUND_CORE_ABORT_EN
  input logic abort,
`endif
  sha2_round_core_if.slave bus
);
  localparam int IDX_W = $clog2(ROUNDS);
  localparam bit WIDE = WORD_W == 64;
  localparam int S0A = WIDE ? 28 : 2;
  localparam int S0B = WIDE ? 34 : 13;
  localparam int S0C = WIDE ? 39 : 22;
  localparam int S1A = WIDE ? 14 : 6;
  localparam int S1B = WIDE ? 18 : 11;
  localparam int S1C = WIDE ? 41 : 25;
  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("sha2_round_core: WORD_W must be 32 or 64");
  end
  if (ROUNDS != 64 && ROUNDS != 80) begin : g_bad_rounds
    $error("sha2_round_core: ROUNDS must be 64 or 80");
  end
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [7:0][WORD_W-1:0] h_reg, work, work_nx, sum, digest;
  logic [WORD_W-1:0] t1, t2;
  logic done, abt;
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
`ifdef SHA2_ROUND_CORE_ABORT_EN
  assign abt = abort && state != IDLE;
`else
  assign abt = 1'b0;
`endif
  // one SHA-2 round over a..h (work[0]..work[7]) and the chaining-value add for the final digest
  always_comb begin
    t1 = work[7] + (rotr(work[4], S1A) ^ rotr(work[4], S1B) ^ rotr(work[4], S1C))
       + ((work[4] & work[5]) ^ (~work[4] & work[6])) + bus.k_in + bus.w_in;
    t2 = (rotr(work[0], S0A) ^ rotr(work[0], S0B) ^ rotr(work[0], S0C))
       + ((work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]));
    work_nx = {work[6], work[5], work[4], work[3] + t1, work[2], work[1], work[0], t1 + t2};
    for (int i = 0; i < 8; i++) sum[i] = h_reg[i] + work[i];
  end
  // next state and handshake outputs; an enabled abort pre-empts any in-flight block
  always_comb begin
    state_nx = abt ? IDLE
             : state == IDLE ? (bus.start ? ROUND : IDLE)
             : state == ROUND ? (idx == IDX_W'(ROUNDS - 1) ? FINAL : ROUND)
             : IDLE;
    bus.ready = state == IDLE;
    bus.busy = state != IDLE;
  end
  // state, round counter, H/working registers and registered result; reset discards the block
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      h_reg <= '0;
      work <= '0;
      digest <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= (state == ROUND && state_nx == ROUND) ? idx + 1'b1 : '0;
      done <= state == FINAL && !abt;
      if (state == IDLE && bus.start) begin
        h_reg <= bus.prev_hash;
        work <= bus.prev_hash;
      end
      if (state == ROUND) work <= work_nx;
      if (state == FINAL && !abt) digest <= sum;
    end
  end
  assign bus.round_idx = idx;
  assign bus.done = done;
  assign bus.digest = digest;
endmodule

// File: tb/tb_sha2_round_core.sv
// tb_sha2_round_core: directed SHA-256 / SHA-512 "abc" vectors, latency, busy-start, reset and abort scenarios
module tb_sha2_round_core;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic zero32 = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};
  localparam logic [255:0] IV256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] DIG256 = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                     32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [511:0] IV512 = {64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f,
                                    64'h510e527fade682d1, 64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
                                    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};

  logic [31:0] w256 [64];
  logic [63:0] w512 [80];

  sha2_round_core_if #(.WORD_W(32), .ROUNDS(64)) bus32();
  sha2_round_core_if #(.WORD_W(64), .ROUNDS(80)) bus64();
`ifdef SHA2_ROUND_CORE_ABORT_EN
  logic abort32 = 1'b0;
  logic abort64 = 1'b0;
`endif

  sha2_round_core #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clock(clock),
    .reset(reset),
`ifdef SHA2_ROUND_CORE_ABORT_EN
    .abort(abort32),
`endif
    .bus(bus32.slave)
  );
  sha2_round_core #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clock(clock),
    .reset(reset),
`ifdef SHA2_ROUND_CORE_ABORT_EN
    .abort(abort64),
`endif
    .bus(bus64.slave)
  );

  assign bus32.w_in = zero32 ? 32'd0 : w256[bus32.round_idx];
  assign bus32.k_in = zero32 ? 32'd0 : K512[bus32.round_idx][63:32];
  assign bus64.w_in = w512[bus64.round_idx];
  assign bus64.k_in = K512[bus64.round_idx];

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic build_schedules();
    for (int t = 0; t < 16; t++) begin
      w256[t] = 32'd0;
      w512[t] = 64'd0;
    end
    w256[0] = 32'h61626380;
    w256[15] = 32'h18;
    w512[0] = 64'h6162638000000000;
    w512[15] = 64'h18;
    for (int t = 16; t < 64; t++)
      w256[t] = (r32(w256[t-2], 17) ^ r32(w256[t-2], 19) ^ (w256[t-2] >> 10)) + w256[t-7]
              + (r32(w256[t-15], 7) ^ r32(w256[t-15], 18) ^ (w256[t-15] >> 3)) + w256[t-16];
    for (int t = 16; t < 80; t++)
      w512[t] = (r64(w512[t-2], 19) ^ r64(w512[t-2], 61) ^ (w512[t-2] >> 6)) + w512[t-7]
              + (r64(w512[t-15], 1) ^ r64(w512[t-15], 8) ^ (w512[t-15] >> 7)) + w512[t-16];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run32(input logic [255:0] hash, input logic zero, output int lat);
    zero32 = zero;
    bus32.prev_hash = hash;
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    lat = 1;
    while (bus32.done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (bus32.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus32.ready); end
    checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus32.busy); end
    checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus32.done); end
    checks++; if (bus32.round_idx !== 6'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bus32.round_idx); end
    checks++; if (bus32.digest !== 256'd0) begin errors++; $display("FAIL reset_digest got=%h exp=0", bus32.digest); end
    checks++; if (bus64.digest !== 512'd0) begin errors++; $display("FAIL reset_digest64 got=%h exp=0", bus64.digest); end
  endtask

  task automatic test_sha512();
    int lat;
    bus64.prev_hash = IV512;
    bus64.start = 1'b1;
    step();
    bus64.start = 1'b0;
    lat = 1;
    while (bus64.done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    checks++; if (lat != 82) begin errors++; $display("FAIL sha512_latency got=%0d exp=82", lat); end
    checks++; if (bus64.digest[63:0] !== 64'hddaf35a193617aba) begin errors++; $display("FAIL sha512_h0 got=%h exp=ddaf35a193617aba", bus64.digest[63:0]); end
    checks++; if (bus64.digest[479:448] !== 32'ha54ca49f) begin errors++; $display("FAIL sha512_h7 got=%h exp=a54ca49f", bus64.digest[479:448]); end
    step();
    checks++; if (bus64.done !== 1'b0) begin errors++; $display("FAIL sha512_done_width got=%b exp=0", bus64.done); end
  endtask

  task automatic test_abc();
    int lat;
    run32(IV256, 1'b0, lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL abc_latency got=%0d exp=66", lat); end
    checks++; if (bus32.digest !== DIG256) begin errors++; $display("FAIL abc_digest got=%h exp=%h", bus32.digest, DIG256); end
    step();
    checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL abc_done_width got=%b exp=0", bus32.done); end
    checks++; if (bus32.digest !== DIG256) begin errors++; $display("FAIL abc_digest_hold got=%h exp=%h", bus32.digest, DIG256); end
  endtask

  task automatic test_zero();
    int lat;
    run32(256'd0, 1'b1, lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL zero_latency got=%0d exp=66", lat); end
    checks++; if (bus32.digest !== 256'd0) begin errors++; $display("FAIL zero_digest got=%h exp=0", bus32.digest); end
    step();
    checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL zero_done_width got=%b exp=0", bus32.done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run32(256'd0, 1'b1, lat);
    checks++; if (bus32.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done got=%b exp=1", bus32.ready); end
    run32(IV256, 1'b0, lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL b2b_latency got=%0d exp=66", lat); end
    checks++; if (bus32.digest !== DIG256) begin errors++; $display("FAIL b2b_digest got=%h exp=%h", bus32.digest, DIG256); end
  endtask

  task automatic test_ignore_start();
    int lat;
    zero32 = 1'b0;
    bus32.prev_hash = IV256;
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    lat = 1;
    while (bus32.round_idx !== 6'd5 && lat < 200) begin
      step();
      lat++;
    end
    checks++; if (bus32.round_idx !== 6'd5) begin errors++; $display("FAIL ign_reach_idx5 got=%0d exp=5", bus32.round_idx); end
    checks++; if (bus32.busy !== 1'b1 || bus32.ready !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b/%b exp=1/0", bus32.busy, bus32.ready); end
    checks++; if (bus32.digest !== DIG256) begin errors++; $display("FAIL ign_digest_hold got=%h exp=%h", bus32.digest, DIG256); end
    bus32.prev_hash = {8{32'h01234567}};
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    lat++;
    while (bus32.done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    checks++; if (lat != 66) begin errors++; $display("FAIL ign_latency got=%0d exp=66", lat); end
    checks++; if (bus32.digest !== DIG256) begin errors++; $display("FAIL ign_digest got=%h exp=%h", bus32.digest, DIG256); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int dones;
    zero32 = 1'b0;
    bus32.prev_hash = IV256;
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    lat = 1;
    while (bus32.round_idx !== 6'd10 && lat < 200) begin
      step();
      lat++;
    end
    checks++; if (bus32.round_idx !== 6'd10) begin errors++; $display("FAIL rst_reach_idx10 got=%0d exp=10", bus32.round_idx); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus32.ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", bus32.ready); end
    checks++; if (bus32.digest !== 256'd0) begin errors++; $display("FAIL rst_mid_digest got=%h exp=0", bus32.digest); end
    checks++; if (bus32.round_idx !== 6'd0) begin errors++; $display("FAIL rst_mid_idx got=%0d exp=0", bus32.round_idx); end
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus32.done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
    run32(IV256, 1'b0, lat);
    checks++; if (lat != 66) begin errors++; $display("FAIL rst_rerun_latency got=%0d exp=66", lat); end
    checks++; if (bus32.digest !== DIG256) begin errors++; $display("FAIL rst_rerun_digest got=%h exp=%h", bus32.digest, DIG256); end
  endtask

`ifdef SHA2_ROUND_CORE_ABORT_EN
  task automatic test_abort();
    int lat;
    int dones;
    zero32 = 1'b1;
    bus32.prev_hash = 256'd0;
    bus32.start = 1'b1;
    step();
    bus32.start = 1'b0;
    lat = 1;
    while (bus32.round_idx !== 6'd30 && lat < 200) begin
      step();
      lat++;
    end
    checks++; if (bus32.round_idx !== 6'd30) begin errors++; $display("FAIL abort_reach_idx30 got=%0d exp=30", bus32.round_idx); end
    abort32 = 1'b1;
    step();
    abort32 = 1'b0;
    checks++; if (bus32.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", bus32.ready); end
    checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus32.done); end
    checks++; if (bus32.digest !== DIG256) begin errors++; $display("FAIL abort_digest got=%h exp=%h", bus32.digest, DIG256); end
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus32.done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    bus32.start = 1'b1;
    abort32 = 1'b1;
    step();
    bus32.start = 1'b0;
    abort32 = 1'b0;
    checks++; if (bus32.busy !== 1'b1) begin errors++; $display("FAIL abort_start_wins got=%b exp=1", bus32.busy); end
    lat = 1;
    while (bus32.done !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    checks++; if (lat != 66) begin errors++; $display("FAIL abort_start_latency got=%0d exp=66", lat); end
    checks++; if (bus32.digest !== 256'd0) begin errors++; $display("FAIL abort_start_digest got=%h exp=0", bus32.digest); end
  endtask
`endif

  initial begin
    bus32.start = 1'b0;
    bus32.prev_hash = '0;
    bus64.start = 1'b0;
    bus64.prev_hash = '0;
    build_schedules();
    test_reset();
    test_sha512();
    test_abc();
    test_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef SHA2_ROUND_CORE_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
